// File: rtl/vend_pkg.sv
// Shared types, coin/product encodings and pricing helpers for the vending
// transaction controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        PAYOUT   = 2'd3
    } vend_state_e;

    localparam logic [2:0] COIN_10 = 3'b001;
    localparam logic [2:0] COIN_20 = 3'b010;
    localparam logic [2:0] COIN_30 = 3'b011;
    localparam logic [2:0] COIN_40 = 3'b100;
    localparam logic [2:0] COIN_50 = 3'b101;

    localparam logic [2:0] PROD_1 = 3'b001;
    localparam logic [2:0] PROD_2 = 3'b010;
    localparam logic [2:0] PROD_3 = 3'b011;

    // Price in 10rs units; 0 marks an unknown product.
    function automatic logic [2:0] price_of(input logic [2:0] prod);
        logic [2:0] price;
        case (prod)
            PROD_1:  price = 3'd1;
            PROD_2:  price = 3'd2;
            PROD_3:  price = 3'd3;
            default: price = 3'd0;
        endcase
        return price;
    endfunction

    // Coin value in 10rs units; 0 marks an unrecognised coin code.
    function automatic logic [2:0] coin_value(input logic [2:0] code);
        logic [2:0] value;
        case (code)
            COIN_10: value = 3'd1;
            COIN_20: value = 3'd2;
            COIN_30: value = 3'd3;
            COIN_40: value = 3'd4;
            COIN_50: value = 3'd5;
            default: value = 3'd0;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/vend_if.sv
// Front-end/actuator signal bundle of the transaction controller; the
// controller is the slave, the coin acceptor/keypad/actuator side the master.
interface vend_if #(
    parameter int CREDIT_W = 4
) ();
    logic                coin_valid;
    logic [2:0]          coin_code;
    logic                sel_valid;
    logic [2:0]          sel_prod;
    logic                cancel;
    logic                disp_ack;
    logic                chg_ack;
    logic                coin_reject;
    logic                sel_nack;
    logic                disp_req;
    logic [2:0]          disp_prod;
    logic                chg_req;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport master (
        output coin_valid, coin_code, sel_valid, sel_prod, cancel, disp_ack, chg_ack,
        input  coin_reject, sel_nack, disp_req, disp_prod, chg_req, credit, busy
    );

    modport slave (
        input  coin_valid, coin_code, sel_valid, sel_prod, cancel, disp_ack, chg_ack,
        output coin_reject, sel_nack, disp_req, disp_prod, chg_req, credit, busy
    );
endinterface

// File: rtl/vend_timeout_ctr.sv
// Idle-timeout counter: counts enabled cycles since the last clear and flags
// the terminal count TIMEOUT_CYC-1.
module vend_timeout_ctr #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Count enabled cycles, saturating at the terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != TERM)) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = en && (cnt_r == TERM);

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: credit accumulation, selection, cancel and
// idle timeout, plus req/ack sequencing of the dispenser and change hopper.
module vend_txn_controller
    import vend_pkg::*;
#(
    parameter int CREDIT_W    = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic  clk,
    input logic  rst,
    vend_if.slave bus
);
    localparam int CW1 = CREDIT_W + 1;
    localparam logic [CW1-1:0]      CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);

    vend_state_e         state_r, state_nxt_s;
    logic [CREDIT_W-1:0] credit_r, credit_nxt_s;
    logic [2:0]          disp_prod_r, disp_prod_nxt_s;
    logic                coin_reject_r, coin_reject_nxt_s;
    logic                sel_nack_r, sel_nack_nxt_s;
    logic                disp_req_r, chg_req_r, busy_r;

    logic [CW1-1:0] credit_ext_s, price_ext_s, coin_sum_s;
    logic           sel_ok_s, coin_ok_s, tmo_tc_s, tmo_clear_s;

    // Widened by one bit so the overflow compare cannot wrap.
    assign credit_ext_s = {1'b0, credit_r};
    assign price_ext_s  = CW1'(price_of(bus.sel_prod));
    assign coin_sum_s   = credit_ext_s + CW1'(coin_value(bus.coin_code));
    assign sel_ok_s     = (price_ext_s != '0) && (credit_ext_s >= price_ext_s);
    assign coin_ok_s    = (coin_value(bus.coin_code) != 3'd0) && (coin_sum_s <= CREDIT_MAX);

    assign tmo_clear_s = bus.coin_valid || bus.sel_valid || (state_r != COLLECT);

    vend_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clear (tmo_clear_s),
        .en    (state_r == COLLECT),
        .tc    (tmo_tc_s)
    );

    // Next-state, credit and strobe-response decode.
    always_comb begin
        state_nxt_s       = state_r;
        credit_nxt_s      = credit_r;
        disp_prod_nxt_s   = disp_prod_r;
        coin_reject_nxt_s = 1'b0;
        sel_nack_nxt_s    = 1'b0;
        case (state_r)
            IDLE, COLLECT: begin
                if (bus.cancel) begin
                    coin_reject_nxt_s = bus.coin_valid;
                    sel_nack_nxt_s    = bus.sel_valid;
                    state_nxt_s       = (credit_r != '0) ? PAYOUT : IDLE;
                end else if (bus.sel_valid && sel_ok_s) begin
                    coin_reject_nxt_s = bus.coin_valid;
                    credit_nxt_s      = credit_r - price_ext_s[CREDIT_W-1:0];
                    disp_prod_nxt_s   = bus.sel_prod;
                    state_nxt_s       = DISPENSE;
                end else begin
                    // A refused selection still lets a same-cycle coin through.
                    sel_nack_nxt_s = bus.sel_valid;
                    if (bus.coin_valid) begin
                        if (coin_ok_s) begin
                            credit_nxt_s = coin_sum_s[CREDIT_W-1:0];
                            state_nxt_s  = COLLECT;
                        end else begin
                            coin_reject_nxt_s = 1'b1;
                        end
                    end else if ((state_r == COLLECT) && tmo_tc_s && !bus.sel_valid) begin
                        state_nxt_s = PAYOUT;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
            end
            DISPENSE: begin
                coin_reject_nxt_s = bus.coin_valid;
                sel_nack_nxt_s    = bus.sel_valid;
                if (bus.disp_ack) begin
                    state_nxt_s = (credit_r != '0) ? PAYOUT : IDLE;
                end else begin
                    state_nxt_s = DISPENSE;
                end
            end
            PAYOUT: begin
                coin_reject_nxt_s = bus.coin_valid;
                sel_nack_nxt_s    = bus.sel_valid;
                if (bus.chg_ack) begin
                    credit_nxt_s = credit_r - CREDIT_ONE;
                    state_nxt_s  = (credit_r == CREDIT_ONE) ? IDLE : PAYOUT;
                end else begin
                    state_nxt_s = PAYOUT;
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                credit_nxt_s = '0;
            end
        endcase
    end

    // FSM state and registered outputs, all derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            credit_r      <= '0;
            disp_prod_r   <= 3'b000;
            coin_reject_r <= 1'b0;
            sel_nack_r    <= 1'b0;
            disp_req_r    <= 1'b0;
            chg_req_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            credit_r      <= credit_nxt_s;
            disp_prod_r   <= disp_prod_nxt_s;
            coin_reject_r <= coin_reject_nxt_s;
            sel_nack_r    <= sel_nack_nxt_s;
            disp_req_r    <= (state_nxt_s == DISPENSE);
            chg_req_r     <= (state_nxt_s == PAYOUT);
            busy_r        <= (state_nxt_s == DISPENSE) || (state_nxt_s == PAYOUT);
        end
    end

    assign bus.coin_reject = coin_reject_r;
    assign bus.sel_nack    = sel_nack_r;
    assign bus.disp_req    = disp_req_r;
    assign bus.disp_prod   = disp_prod_r;
    assign bus.chg_req     = chg_req_r;
    assign bus.credit      = credit_r;
    assign bus.busy        = busy_r;

endmodule
